rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_arbiter_arb_pick.sv | 33 +++
 rtl/rom_arbiter.sv | 142 ++++++++++++++
 tb/tb_rom_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-requester ROM arbiter.
// Policy macro ROM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
package rom_arb_pkg;

    localparam int ADDR_W_DEF  = 3;
    localparam int DATA_W_DEF  = 16;
    localparam int ROM_LAT_DEF = 2;

    // Wide enough for the largest supported latency (7).
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rom_arbiter_arb_pick.sv
// Two-way winner select for the ROM arbiter.
// ROM_ARB_RR_EN defined: round-robin on last-served pointer; undefined: req0 always wins.
module arb_pick
    import rom_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    output logic pick_valid,
    output logic pick_id
`ifdef ROM_ARB_RR_EN
    ,
    input  logic last_ptr
`endif
);

    // Winner select; pick_id 0 = requester 0, 1 = requester 1.
    always_comb begin
        pick_valid = req0 | req1;
        pick_id    = 1'b0;
        if (req0 && req1) begin
`ifdef ROM_ARB_RR_EN
            pick_id = ~last_ptr;
`else
            pick_id = 1'b0;
`endif
        end else if (req1) begin
            pick_id = 1'b1;
        end else begin
            pick_id = 1'b0;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two read requesters onto one synchronous ROM, one read in flight.
// ROM_ARB_RR_EN selects round-robin arbitration; default build is fixed priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              vld0,
    output logic              vld1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              vld0_q, vld0_d, vld1_q, vld1_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic              pick_valid, pick_id;
`ifdef ROM_ARB_RR_EN
    logic              ptr_q, ptr_d;
`endif

    arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
`ifdef ROM_ARB_RR_EN
        ,
        .last_ptr   (ptr_q)
`endif
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        owner_d    = owner_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        vld0_d     = 1'b0;
        vld1_d     = 1'b0;
`ifdef ROM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = WAIT;
                    owner_d    = pick_id;
                    rom_addr_d = pick_id ? addr1 : addr0;
                    gnt0_d     = ~pick_id;
                    gnt1_d     = pick_id;
                    cnt_d      = CNT_W'(ROM_LAT - 1);
`ifdef ROM_ARB_RR_EN
                    ptr_d      = pick_id;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Counter ran ROM_LAT cycles from the grant: ROM output is settled.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                rdata_d = rom_data;
                vld0_d  = ~owner_q;
                vld1_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rom_addr_q <= {ADDR_W{1'b0}};
            rdata_q    <= {DATA_W{1'b0}};
            owner_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ROM_ARB_RR_EN
            ptr_q      <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            owner_q    <= owner_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            busy_q     <= busy_d;
`ifdef ROM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign vld0     = vld0_q;
    assign vld1     = vld1_q;
    assign busy     = busy_q;
    assign rdata    = rdata_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter against a transaction-level model.
// Honours ROM_ARB_RR_EN the same way as the design.
module tb_rom_arbiter;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, vld0, vld1, busy;
    logic [DW-1:0] rdata, rom_data;
    logic [AW-1:0] rom_addr;

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .vld0(vld0), .vld1(vld1),
        .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    // Synchronous ROM with L cycles of latency from rom_addr.
    logic [DW-1:0] mem  [8];
    logic [DW-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= mem[rom_addr];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data = pipe[L-1];

    // Transaction-level model state.
    int            edge_n = 0;
    bit            m_active = 1'b0;
    int            m_t = 0;
    bit            m_owner = 1'b0;
    bit            m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] e_rdata = '0;
    logic [AW-1:0] e_rom_addr = '0;
    bit            e_gnt0, e_gnt1, e_vld0, e_vld1, e_busy;

    int  total = 0;
    int  bad = 0;
    int  n_gnt0 = 0;
    int  n_gnt1 = 0;
    bit  hold0 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    // Apply one clock edge to the model, given the inputs seen at that edge.
    task automatic model_edge(input bit rs, input bit r0, input bit r1,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bit w;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_vld0 = 1'b0; e_vld1 = 1'b0;
        if (!rs) begin
            m_active = 1'b0; m_last = 1'b1; e_busy = 1'b0;
            e_rdata = '0; e_rom_addr = '0;
        end else if (m_active && edge_n == m_t + L + 1) begin
            e_rdata = mem[m_addr];
            e_vld0 = ~m_owner; e_vld1 = m_owner;
            m_active = 1'b0; e_busy = 1'b0;
        end else if (m_active) begin
            e_busy = 1'b1;
        end else if (r0 || r1) begin
            if (r0 && r1) begin
`ifdef ROM_ARB_RR_EN
                w = ~m_last;
`else
                w = 1'b0;
`endif
            end else begin
                w = r1;
            end
            m_active = 1'b1; m_t = edge_n; m_owner = w; m_last = w;
            m_addr = w ? a1 : a0;
            e_rom_addr = m_addr;
            e_gnt0 = ~w; e_gnt1 = w; e_busy = 1'b1;
        end else begin
            e_busy = 1'b0;
        end
    endtask

    task automatic cycle();
        bit rs, r0, r1;
        logic [AW-1:0] a0, a1;
        rs = rst; r0 = req0; r1 = req1; a0 = addr0; a1 = addr1;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(rs, r0, r1, a0, a1);
        check("gnt0", {31'd0, gnt0}, {31'd0, e_gnt0});
        check("gnt1", {31'd0, gnt1}, {31'd0, e_gnt1});
        check("vld0", {31'd0, vld0}, {31'd0, e_vld0});
        check("vld1", {31'd0, vld1}, {31'd0, e_vld1});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("rom_addr", {29'd0, rom_addr}, {29'd0, e_rom_addr});
        check("rdata", {16'd0, rdata}, {16'd0, e_rdata});
        if (gnt0 === 1'b1) n_gnt0++;
        if (gnt1 === 1'b1) n_gnt1++;
        if (gnt0 === 1'b1 && !hold0) req0 = 1'b0;
        if (gnt1 === 1'b1) req1 = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        mem[3] = 16'h1A2B;
        mem[6] = 16'hBEEF;

        rst = 1'b0;
        run(3);
        rst = 1'b1;
        run(2);

        // Single read from requester 0.
        req0 = 1'b1; addr0 = 3'd3;
        run(6);

        // Contention, then contention again.
        req0 = 1'b1; addr0 = 3'd1; req1 = 1'b1; addr1 = 3'd5;
        run(10);
        req0 = 1'b1; addr0 = 3'd2; req1 = 1'b1; addr1 = 3'd4;
        run(10);

        // Requester 0 held continuously against requester 1.
        n_gnt1 = 0;
        hold0 = 1'b1; req0 = 1'b1; addr0 = 3'd7; req1 = 1'b1; addr1 = 3'd0;
        run(16);
`ifdef ROM_ARB_RR_EN
        check("rr_gnt1_served", {31'd0, n_gnt1 != 0}, 32'd1);
`else
        check("fixed_gnt1_starved", n_gnt1, 32'd0);
`endif
        hold0 = 1'b0; req0 = 1'b0;
        run(8);

        // Request arriving during WAIT of another read.
        req0 = 1'b1; addr0 = 3'd2;
        run(2);
        req1 = 1'b1; addr1 = 3'd6;
        run(8);

        // Reset two cycles after a grant aborts the read.
        req0 = 1'b1; addr0 = 3'd5;
        run(2);
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        run(5);
        req0 = 1'b1; addr0 = 3'd3;
        run(6);

        // Read 16'hBEEF then idle.
        req1 = 1'b1; addr1 = 3'd6;
        run(5);
        n_gnt0 = 0; n_gnt1 = 0;
        run(10);
        check("idle_rdata_hold", {16'd0, rdata}, 32'h0000BEEF);
        check("idle_no_grants", n_gnt0 + n_gnt1, 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (!req0 && $urandom_range(3) == 0) begin
                req0 = 1'b1; addr0 = AW'($urandom);
            end
            if (!req1 && $urandom_range(3) == 0) begin
                req1 = 1'b1; addr1 = AW'($urandom);
            end
            rst = ($urandom_range(59) == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        run(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
